// File: rtl/mul_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mul_issue_ctrl
//
// Control stage around the 2-stage multiplier in the EXE->MEM path.
// It accepts MUL.W / MULH.W / MULH.WU ops from EXE and drives the multiplier
// operands and signedness. Ops are tracked through the multiplier's
// free-running pipeline register. Each product is written into a small result
// FIFO, so backpressure from MEM never drops a result.
//
// Optional build macro:
//   MUL_ISSUE_BYPASS_EN - when the FIFO is empty, a landing product is offered
//                         to MEM in the cycle it lands. It skips the FIFO if MEM
//                         takes it in that cycle.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   in_valid / in_ready     op handshake from EXE
//   in_op                   00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 treated as 00
//   in_src1 / in_src2       operands
//   in_tag                  destination tag carried with the op
//   flush                   cancels every op held in this block
//   mul_a / mul_b           operands to the multiplier (combinational)
//   mul_signed              signedness to the multiplier
//   mul_result              64-bit product, MUL_LAT cycles after the operands
//   out_valid / out_ready   result handshake to MEM
//   out_data / out_tag      selected 32-bit result half and its tag
//   busy                    any op in flight or buffered
// -----------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_signed,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);

  // In-flight tracking, one entry per multiplier pipeline stage
  logic [MUL_LAT-1:0] pipe_vld_q;
  logic [MUL_LAT-1:0] pipe_hi_q;
  logic [TAG_W-1:0]   pipe_tag_q [MUL_LAT];

  // Result FIFO
  logic [31:0]        fifo_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   fifo_tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;

  logic               kill;
  logic               accept;
  logic               hi_sel_in;
  logic               last_vld;
  logic               last_hi;
  logic [TAG_W-1:0]   last_tag;
  logic [31:0]        land_data;
  logic               fifo_nonempty;
  logic               fifo_out_vld;
  logic               byp_vld;
  logic               byp_take;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Multiplier drive: operands pass straight through; only MULH.WU is unsigned
  // ---------------------------------------------------------------------------
  assign mul_a      = in_src1;
  assign mul_b      = in_src2;
  assign mul_signed = (in_op != 2'b10);

  assign hi_sel_in  = (in_op == 2'b01) || (in_op == 2'b10);

  // ---------------------------------------------------------------------------
  // Landing product: when the last stage is valid, mul_result belongs to it
  // ---------------------------------------------------------------------------
  assign last_vld  = pipe_vld_q[MUL_LAT-1];
  assign last_hi   = pipe_hi_q[MUL_LAT-1];
  assign last_tag  = pipe_tag_q[MUL_LAT-1];
  assign land_data = last_hi ? mul_result[63:32] : mul_result[31:0];

  // Reset has the same effect as flush. Both stop accept, pop and push.
  assign kill          = reset || flush;
  assign fifo_nonempty = (count_q != '0);
  assign fifo_out_vld  = fifo_nonempty && !kill;

`ifdef MUL_ISSUE_BYPASS_EN
  // Present the landing product directly only when nothing older is queued.
  // This keeps results in order.
  assign byp_vld  = !fifo_nonempty && last_vld && !kill;
  assign byp_take = byp_vld && out_ready;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign out_valid = fifo_out_vld || byp_vld;

  always_comb begin
    out_data = '0;
    out_tag  = '0;
    if (fifo_out_vld) begin
      out_data = fifo_data_q[rd_ptr_q];
      out_tag  = fifo_tag_q[rd_ptr_q];
    end else if (byp_vld) begin
      out_data = land_data;
      out_tag  = last_tag;
    end
  end

  assign pop  = fifo_out_vld && out_ready;
  assign push = last_vld && !kill && !byp_take;

  // ---------------------------------------------------------------------------
  // Occupancy is every op the block owns: in flight plus buffered.
  // An op is accepted only if a FIFO slot is guaranteed for it when it lands.
  // A same-cycle pop also frees a slot, which gives full throughput.
  // ---------------------------------------------------------------------------
  always_comb begin
    occ = OCC_W'(count_q);
    for (int i = 0; i < MUL_LAT; i++) begin
      occ = occ + OCC_W'(pipe_vld_q[i]);
    end
  end

  assign in_ready = !kill &&
                    ((occ < OCC_W'(FIFO_DEPTH)) || (out_valid && out_ready));
  assign accept   = in_valid && in_ready;

  assign busy = (|pipe_vld_q) || fifo_nonempty;

  // ---------------------------------------------------------------------------
  // FIFO pointer and count next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state. Flush clears the same state as reset. The product that is
  // still landing is dropped because push is blocked.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload registers carry no reset. The valid bits and the count qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      pipe_hi_q[0]  <= hi_sel_in;
      pipe_tag_q[0] <= in_tag;
    end
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_hi_q[i]  <= pipe_hi_q[i-1];
      pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= land_data;
      fifo_tag_q[wr_ptr_q]  <= last_tag;
    end
  end

`ifndef SYNTHESIS
  // The admission rule must keep the owned op count within the FIFO size.
  // That guarantee is what makes a push into a full FIFO impossible.
  occ_within_depth: assert property (
    @(posedge clk) disable iff (reset) occ <= OCC_W'(FIFO_DEPTH));

  no_push_when_full: assert property (
    @(posedge clk) disable iff (reset)
    push |-> ((count_q < CNT_W'(FIFO_DEPTH)) || pop));
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  localparam int TAG_W      = 5;
  localparam int FIFO_DEPTH = 2;
`ifdef MUL_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_signed;
  logic [63:0]      mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  mul_issue_ctrl #(.MUL_LAT(1), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .flush      (flush),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: one free-running register stage
  always @(posedge clk) begin
    if (mul_signed)
      mul_result <= 64'($signed(mul_a)) * 64'($signed(mul_b));
    else
      mul_result <= {32'b0, mul_a} * {32'b0, mul_b};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference result computed from the op semantics
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    logic [63:0]     v;
    sp = longint'(signed'(a)) * longint'(signed'(b));
    up = longint'({32'b0, a}) * longint'({32'b0, b});
    case (op)
      2'b01:   begin v = sp; return v[63:32]; end
      2'b10:   begin v = up; return v[63:32]; end
      default: begin v = sp; return v[31:0];  end
    endcase
  endfunction

  // Scoreboard monitor: the model owns every accepted, unemitted op
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ov, exp_ir;
      exp_ov = !reset && !flush && (q.size() > 0) && ((cyc - q[0].acc_cyc) >= LAT);
      exp_ir = !reset && !flush && ((q.size() < FIFO_DEPTH) || (exp_ov && out_ready));
      chk("mon_out_valid", 64'(out_valid), 64'(exp_ov));
      chk("mon_in_ready",  64'(in_ready),  64'(exp_ir));
      chk("mon_busy",      64'(busy),      64'(q.size() != 0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("mon_unexpected_out", 64'(1), 64'(0));
        end else begin
          chk("mon_out_data", 64'(out_data), 64'(q[0].data));
          chk("mon_out_tag",  64'(out_tag),  64'(q[0].tag));
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data    = ref_res(in_op, in_src1, in_src2);
        e.tag     = in_tag;
        e.acc_cyc = cyc;
        q.push_back(e);
      end
      if (reset || flush) q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = t;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = '0; in_src2 = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_tag",   64'(out_tag),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // MUL.W 3 * -1
    step(); drive_op(2'b00, 32'h3, 32'hFFFF_FFFF, 5'd5); out_ready = 1'b1;
    @(negedge clk); chk("t1_accept", 64'(in_ready), 64'(1));
    step(); in_valid = 1'b0;
    @(negedge clk);
    if (LAT == 2) chk("t1_not_early", 64'(out_valid), 64'(0));
    if (LAT == 2) begin step(); @(negedge clk); end
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_data",  64'(out_data),  64'(32'hFFFF_FFFD));
    chk("t1_tag",   64'(out_tag),   64'(5));
    step(); @(negedge clk);

    // MULH.W then MULH.WU of -1 * -1, back-to-back
    step(); drive_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    step(); drive_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("t2_mulh_valid", 64'(out_valid), 64'(1));
    chk("t2_mulh_data",  64'(out_data),  64'(32'h0000_0000));
    chk("t2_mulh_tag",   64'(out_tag),   64'(6));
    step(); @(negedge clk);
    chk("t2_mulhu_valid", 64'(out_valid), 64'(1));
    chk("t2_mulhu_data",  64'(out_data),  64'(32'hFFFF_FFFE));
    chk("t2_mulhu_tag",   64'(out_tag),   64'(7));
    repeat (2) step();

    // Four ops back-to-back at full throughput
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 4) drive_op(2'b00, 32'(i + 2), 32'd10, 5'(i + 1));
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) chk("t3_in_ready", 64'(in_ready), 64'(1));
      if (i >= 2) begin
        chk("t3_out_valid", 64'(out_valid), 64'(1));
        chk("t3_out_tag",   64'(out_tag),   64'(i - 1));
      end
    end
    repeat (2) step();

    // Backpressure: the third op waits until MEM drains
    out_ready = 1'b0;
    step(); drive_op(2'b00, 32'd7, 32'd7, 5'd7);
    @(negedge clk); chk("t4_acc1", 64'(in_ready), 64'(1));
    step(); drive_op(2'b00, 32'd8, 32'd8, 5'd8);
    @(negedge clk); chk("t4_acc2", 64'(in_ready), 64'(1));
    step(); drive_op(2'b00, 32'd9, 32'd9, 5'd9);
    @(negedge clk); chk("t4_full_a", 64'(in_ready), 64'(0));
    step();
    @(negedge clk); chk("t4_full_b", 64'(in_ready), 64'(0));
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 64'(in_ready), 64'(1));
    chk("t4_pop_tag7",      64'(out_tag),  64'(7));
    step(); in_valid = 1'b0;
    @(negedge clk); chk("t4_pop_tag8", 64'(out_tag), 64'(8));
    step();
    @(negedge clk);
    chk("t4_pop9_valid", 64'(out_valid), 64'(1));
    chk("t4_pop_tag9",   64'(out_tag),   64'(9));
    chk("t4_pop_data9",  64'(out_data),  64'(81));
    repeat (2) step();

    // Flush kills in-flight and buffered ops
    out_ready = 1'b0;
    step(); drive_op(2'b00, 32'd2, 32'd3, 5'd10);
    step(); drive_op(2'b00, 32'd4, 32'd5, 5'd11);
    step(); in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ov", 64'(out_valid), 64'(0));
    chk("t5_flush_ir", 64'(in_ready),  64'(0));
    step(); flush = 1'b0; out_ready = 1'b1; drive_op(2'b00, 32'd6, 32'd7, 5'd12);
    @(negedge clk);
    chk("t5_post_busy", 64'(busy),      64'(0));
    chk("t5_post_ov",   64'(out_valid), 64'(0));
    chk("t5_post_ir",   64'(in_ready),  64'(1));
    step(); in_valid = 1'b0;
    if (LAT == 2) begin
      @(negedge clk); chk("t5_no_stale", 64'(out_valid), 64'(0));
      step();
    end
    @(negedge clk);
    chk("t5_new_valid", 64'(out_valid), 64'(1));
    chk("t5_new_tag",   64'(out_tag),   64'(12));
    chk("t5_new_data",  64'(out_data),  64'(42));
    repeat (2) step();

    // Reset with the FIFO full
    out_ready = 1'b0;
    step(); drive_op(2'b00, 32'd1, 32'd13, 5'd13);
    step(); drive_op(2'b00, 32'd1, 32'd14, 5'd14);
    step(); in_valid = 1'b0;
    step(); reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_ov", 64'(out_valid), 64'(0));
    chk("t6_rst_ir", 64'(in_ready),  64'(0));
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t6_after_ov",   64'(out_valid), 64'(0));
    chk("t6_after_busy", 64'(busy),      64'(0));
    chk("t6_after_ir",   64'(in_ready),  64'(1));
    chk("t6_after_data", 64'(out_data),  64'(0));
    chk("t6_after_tag",  64'(out_tag),   64'(0));

    // Randomized traffic with backpressure, flushes and resets
    for (int n = 0; n < 600; n++) begin
      step();
      in_valid  = ($urandom_range(0, 99) < 70);
      in_op     = 2'($urandom_range(0, 3));
      in_src1   = pick();
      in_src2   = pick();
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 199) < 1);
    end

    // Drain
    step();
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("drain_busy",      64'(busy),      64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));
    chk("drain_model",     64'(q.size()),  64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Control stage wrapped around the 2-stage Wallace/Booth multiplier in the EXE→MEM path.
- Accepts MUL.W / MULH.W / MULH.WU ops from EXE via valid/ready and drives the multiplier's operands and signedness.
- Tracks in-flight ops through the multiplier's free-running (non-stallable) pipeline register.
- Captures products into a result FIFO and selects the 32-bit half, so MEM backpressure never drops a result.

Parameters:
- MUL_LAT, 1, cycles from operand presentation to valid product on mul_result; fixed by the multiplier.
- FIFO_DEPTH, 2, result-buffer entries; must be >= MUL_LAT+1.
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EXE presents a multiply op
- in_ready  out  1  op accepted when in_valid&&in_ready
- in_op  in  2  00 MUL.W, 01 MULH.W, 10 MULH.WU, 11 reserved (treated as 00)
- in_src1  in  32  multiplicand
- in_src2  in  32  multiplier
- in_tag  in  TAG_W  destination tag
- flush  in  1  exception/ERTN cancel; kills all ops in this block
- mul_a  out  32  to multiplier A (= in_src1, combinational)
- mul_b  out  32  to multiplier B (= in_src2, combinational)
- mul_signed  out  1  to multiplier; 1 unless in_op==10
- mul_result  in  64  product from multiplier
- out_valid  out  1  result available to MEM
- out_ready  in  1  MEM consumes when out_valid&&out_ready
- out_data  out  32  selected result half
- out_tag  out  TAG_W  tag of out_data
- busy  out  1  any op in flight or buffered

Behaviour:
- Reset, applied at the clk edge: in-flight shift register valid bits = 0, FIFO pointers and count = 0.
- Reset values: out_valid=0, busy=0, out_data/out_tag = 0.
- in_ready = 0 while reset or flush is high.
- In-flight pipe: MUL_LAT stages of {valid, hi_sel, tag}. An accept loads stage 0 at the edge. hi_sel = (in_op==01 || in_op==10).
- When the last stage is valid, mul_result belongs to that op. At the next edge, push {hi_sel ? mul_result[63:32] : mul_result[31:0], tag} into the FIFO.
- Occupancy = (valid in-flight stages) + FIFO count.
- in_ready = !reset && !flush && (occupancy < FIFO_DEPTH || (out_valid && out_ready)). The combinational out_ready→in_ready path is intentional and gives full throughput.
- Invariant: occupancy never exceeds FIFO_DEPTH, so a push never hits a full FIFO. An assertion fires on violation.
- out_valid = FIFO non-empty && !flush. out_data/out_tag come from the FIFO head; pop on out_valid&&out_ready.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: accept in cycle N → out_valid in cycle N+MUL_LAT+1 (N+2 by default).
- Throughput: 1 op/cycle with out_ready held high.
- Order: strictly in order; results exit in accept order.
- Flush cycle: no accept, no pop, no push. At the edge, all in-flight valids and the FIFO are cleared. The product still landing in the multiplier register is ignored.
- Reset mid-operation: same clearing as flush. Nothing is emitted for killed ops.
- busy = |inflight_valid || FIFO non-empty.
- mul_a/mul_b/mul_signed are driven regardless of in_valid; the multiplier output is meaningful only when tracked as valid.

Optional Feature:
- Macro: MUL_ISSUE_BYPASS_EN.
- Defined:
  - When the FIFO is empty, the last in-flight stage is valid and flush is low, drive out_valid=1 combinationally with the selected half of mul_result.
  - If out_ready, the result is consumed and not pushed. Otherwise it is pushed as normal.
  - Latency becomes N+MUL_LAT.
- Not defined: results always pass through the FIFO; latency is N+MUL_LAT+1.

Test Plan:
- MUL.W 0x00000003*0xFFFFFFFF, tag 5, out_ready=1 → out_valid at N+2, out_data=0xFFFFFFFD, out_tag=5.
- MULH.W then MULH.WU, both 0xFFFFFFFF*0xFFFFFFFF, back-to-back → 0x00000000 then 0xFFFFFFFE in consecutive cycles, in order.
- 4 ops in cycles N..N+3 (tags 1..4), out_ready=1 → in_ready stays 1, results at N+2..N+5 with tags 1..4.
- out_ready=0, 3 ops offered → in_ready=0 after 2 accepts. Raise out_ready: tags pop in order, third op is then accepted, no result lost.
- 2 ops in flight/buffered, flush=1 for one cycle → out_valid never asserts for them, busy=0 next cycle, new op afterwards completes normally.
- reset asserted with FIFO full → next cycle out_valid=0, busy=0, in_ready=1 once reset drops.
